// File: rtl/mmu_arbiter.sv
// mmu_arbiter
//   Two-port round-robin arbiter in front of a single MMU access channel.
//   Port 0 is instruction fetch, port 1 is load/store. One transaction is in
//   flight at a time: IDLE -> ISSUE -> WAIT (LATENCY-1 cycles) -> DONE -> IDLE.
//
// Parameters
//   ADDR_WIDTH  width of all address ports
//   DATA_WIDTH  width of all data ports
//   LATENCY     cycles from m_op issue to m_data_r valid (1..15)
//
// Ports
//   sys_clk, sys_rst              clock, asynchronous active-high reset
//   pN_req/rw/addr/data_w         per-port request, direction (1=write),
//                                 byte address, write data
//   pN_ack, pN_data_r             one-cycle completion pulse, registered read data
//   busy                          high whenever the arbiter is not IDLE
//   m_op, m_rw, m_addr, m_data_w  MMU strobe, direction, address, write data
//   m_data_r                      MMU read data
module mmu_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LATENCY    = 1
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  p0_req,
   input  logic                  p1_req,
   input  logic                  p0_rw,
   input  logic                  p1_rw,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p0_data_w,
   input  logic [DATA_WIDTH-1:0] p1_data_w,
   output logic                  p0_ack,
   output logic                  p1_ack,
   output logic [DATA_WIDTH-1:0] p0_data_r,
   output logic [DATA_WIDTH-1:0] p1_data_r,
   output logic                  busy,
   output logic                  m_op,
   output logic                  m_rw,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [DATA_WIDTH-1:0] m_data_w,
   input  logic [DATA_WIDTH-1:0] m_data_r
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam bit         SKIP_WAIT = (LATENCY <= 1);
   // Counter runs LATENCY-2 down to 0, giving LATENCY-1 WAIT cycles.
   localparam logic [3:0] WAIT_INIT = SKIP_WAIT ? 4'd0 : 4'(LATENCY - 2);

   state_t                state_q;
   logic                  grant_q;     // port owning the transaction in flight
   logic                  last_q;      // port granted last; 1 after reset so port 0 wins a tie
   logic [3:0]            wait_cnt_q;
   logic                  m_op_q;
   logic                  m_rw_q;
   logic [ADDR_WIDTH-1:0] m_addr_q;
   logic [DATA_WIDTH-1:0] m_data_w_q;
   logic                  p0_ack_q;
   logic                  p1_ack_q;
   logic [DATA_WIDTH-1:0] p0_data_r_q;
   logic [DATA_WIDTH-1:0] p1_data_r_q;

   logic                  grant_d;
   logic                  to_done;

   always_comb begin
      grant_d = 1'b0;
      if (p0_req && p1_req) begin
         grant_d = ~last_q;
      end else if (p1_req) begin
         grant_d = 1'b1;
      end
   end

   // Edge that enters DONE: ack and read data are registered here so both
   // are visible together during the DONE cycle.
   assign to_done = ((state_q == ISSUE) && SKIP_WAIT) ||
                    ((state_q == WAIT) && (wait_cnt_q == 4'd0));

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_q       <= 1'b1;
         wait_cnt_q   <= '0;
         m_op_q       <= 1'b0;
         m_rw_q       <= 1'b0;
         m_addr_q     <= '0;
         m_data_w_q   <= '0;
         p0_ack_q     <= 1'b0;
         p1_ack_q     <= 1'b0;
         p0_data_r_q  <= '0;
         p1_data_r_q  <= '0;
      end else begin
         m_op_q   <= 1'b0;
         p0_ack_q <= 1'b0;
         p1_ack_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (p0_req || p1_req) begin
                  grant_q    <= grant_d;
                  m_rw_q     <= grant_d ? p1_rw     : p0_rw;
                  m_addr_q   <= grant_d ? p1_addr   : p0_addr;
                  m_data_w_q <= grant_d ? p1_data_w : p0_data_w;
                  m_op_q     <= 1'b1;
                  state_q    <= ISSUE;
               end
            end
            ISSUE: begin
               wait_cnt_q <= WAIT_INIT;
               state_q    <= SKIP_WAIT ? DONE : WAIT;
            end
            WAIT: begin
               if (wait_cnt_q == 4'd0) begin
                  state_q <= DONE;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 4'd1;
               end
            end
            DONE: begin
               last_q  <= grant_q;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase

         if (to_done) begin
            if (grant_q) begin
               p1_ack_q <= 1'b1;
               if (!m_rw_q) p1_data_r_q <= m_data_r;
            end else begin
               p0_ack_q <= 1'b1;
               if (!m_rw_q) p0_data_r_q <= m_data_r;
            end
         end
      end
   end

   assign busy      = (state_q != IDLE);
   assign m_op      = m_op_q;
   assign m_rw      = m_rw_q;
   assign m_addr    = m_addr_q;
   assign m_data_w  = m_data_w_q;
   assign p0_ack    = p0_ack_q;
   assign p1_ack    = p1_ack_q;
   assign p0_data_r = p0_data_r_q;
   assign p1_data_r = p1_data_r_q;

endmodule

// File: tb/tb_mmu_arbiter.sv
module tb_mmu_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // LATENCY=1 instance
   logic          p0_req, p1_req, p0_rw, p1_rw;
   logic [AW-1:0] p0_addr, p1_addr;
   logic [DW-1:0] p0_data_w, p1_data_w;
   logic          p0_ack, p1_ack, busy, m_op, m_rw;
   logic [DW-1:0] p0_data_r, p1_data_r, m_data_w, m_data_r;
   logic [AW-1:0] m_addr;

   // LATENCY=3 instance
   logic          t_p0_req, t_p1_req, t_p0_rw, t_p1_rw;
   logic [AW-1:0] t_p0_addr, t_p1_addr;
   logic [DW-1:0] t_p0_data_w, t_p1_data_w;
   logic          t_p0_ack, t_p1_ack, t_busy, t_m_op, t_m_rw;
   logic [DW-1:0] t_p0_data_r, t_p1_data_r, t_m_data_w, t_m_data_r;
   logic [AW-1:0] t_m_addr;

   mmu_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(1)) dut (
      .sys_clk(clk), .sys_rst(rst),
      .p0_req(p0_req), .p1_req(p1_req), .p0_rw(p0_rw), .p1_rw(p1_rw),
      .p0_addr(p0_addr), .p1_addr(p1_addr),
      .p0_data_w(p0_data_w), .p1_data_w(p1_data_w),
      .p0_ack(p0_ack), .p1_ack(p1_ack),
      .p0_data_r(p0_data_r), .p1_data_r(p1_data_r),
      .busy(busy), .m_op(m_op), .m_rw(m_rw), .m_addr(m_addr),
      .m_data_w(m_data_w), .m_data_r(m_data_r)
   );

   mmu_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(3)) dut3 (
      .sys_clk(clk), .sys_rst(rst),
      .p0_req(t_p0_req), .p1_req(t_p1_req), .p0_rw(t_p0_rw), .p1_rw(t_p1_rw),
      .p0_addr(t_p0_addr), .p1_addr(t_p1_addr),
      .p0_data_w(t_p0_data_w), .p1_data_w(t_p1_data_w),
      .p0_ack(t_p0_ack), .p1_ack(t_p1_ack),
      .p0_data_r(t_p0_data_r), .p1_data_r(t_p1_data_r),
      .busy(t_busy), .m_op(t_m_op), .m_rw(t_m_rw), .m_addr(t_m_addr),
      .m_data_w(t_m_data_w), .m_data_r(t_m_data_r)
   );

   // MMU model for the LATENCY=1 instance: word memory written on m_op.
   logic [DW-1:0] mem [0:63];
   always @(posedge clk) if (m_op && m_rw) mem[m_addr[7:2]] <= m_data_w;
   assign m_data_r = mem[m_addr[7:2]];

   // MMU model for the LATENCY=3 instance: data derived from the address.
   assign t_m_data_r = t_m_addr ^ 32'h5A5A_0000;

   typedef struct {
      bit            port;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
   } exp_t;
   exp_t sb[$];

   int tests_run = 0;
   int fails     = 0;
   logic [DW-1:0] exp_p0r, exp_p1r, t_exp_p0r, t_exp_p1r;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({m_op, m_rw, m_addr, m_data_w, p0_ack, p1_ack, p0_data_r, p1_data_r, busy} !== '0) begin
         fails++;
         $display("FAIL reset_l1: got %h required 0",
                  {m_op, m_rw, m_addr, m_data_w, p0_ack, p1_ack, p0_data_r, p1_data_r, busy});
      end
      tests_run++;
      if ({t_m_op, t_m_rw, t_m_addr, t_m_data_w, t_p0_ack, t_p1_ack, t_p0_data_r, t_p1_data_r, t_busy} !== '0) begin
         fails++;
         $display("FAIL reset_l3: got %h required 0",
                  {t_m_op, t_m_rw, t_m_addr, t_m_data_w, t_p0_ack, t_p1_ack, t_p0_data_r, t_p1_data_r, t_busy});
      end
      exp_p0r = '0; exp_p1r = '0; t_exp_p0r = '0; t_exp_p1r = '0;
      rst = 1'b0;
   endtask

   // Single transaction on the LATENCY=1 instance.
   task automatic txn(input bit port, input bit rw, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rd, input string nm);
      exp_t e;
      bit   got = 0;
      e.port = port; e.d0 = exp_p0r; e.d1 = exp_p1r;
      if (!rw) begin
         if (port) e.d1 = rd; else e.d0 = rd;
      end
      sb.push_back(e);
      if (!port) begin
         p0_req = 1'b1; p0_rw = rw; p0_addr = addr; p0_data_w = wd;
      end else begin
         p1_req = 1'b1; p1_rw = rw; p1_addr = addr; p1_data_w = wd;
      end
      for (int k = 1; k <= 10 && !got; k++) begin
         @(negedge clk);
         tests_run++;
         if (k == 1) begin
            if ({m_op, m_rw, m_addr, m_data_w} !== {1'b1, rw, addr, wd}) begin
               fails++;
               $display("FAIL %s_issue: got op/rw/addr/wd %h required %h", nm,
                        {m_op, m_rw, m_addr, m_data_w}, {1'b1, rw, addr, wd});
            end
         end else if (m_op !== 1'b0) begin
            fails++;
            $display("FAIL %s_mop_low: cycle %0d got m_op %b required 0", nm, k, m_op);
         end
         if (p0_ack || p1_ack) begin
            got = 1;
            e = sb.pop_front();
            tests_run++;
            if (k != 2) begin
               fails++;
               $display("FAIL %s_latency: ack at cycle %0d required 2", nm, k);
            end
            tests_run++;
            if ({p0_ack, p1_ack} !== (e.port ? 2'b01 : 2'b10)) begin
               fails++;
               $display("FAIL %s_ack_port: got %b required %b", nm, {p0_ack, p1_ack},
                        (e.port ? 2'b01 : 2'b10));
            end
            tests_run++;
            if ({p0_data_r, p1_data_r} !== {e.d0, e.d1}) begin
               fails++;
               $display("FAIL %s_data_r: got %h required %h", nm, {p0_data_r, p1_data_r}, {e.d0, e.d1});
            end
            exp_p0r = e.d0; exp_p1r = e.d1;
         end
      end
      if (!got) begin
         tests_run++; fails++;
         $display("FAIL %s_timeout: no ack within 10 cycles", nm);
         void'(sb.pop_front());
      end
      p0_req = 1'b0; p1_req = 1'b0;
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL %s_idle: got busy %b required 0", nm, busy);
      end
   endtask

   task automatic test_write_p0();
      txn(1'b0, 1'b1, 32'h10, 32'hA5A5_A5A5, '0, "wr_p0");
   endtask

   task automatic test_back_to_back();
      txn(1'b1, 1'b1, 32'h14, 32'h1234_5678, '0, "wr_p1");
   endtask

   task automatic test_read_p1();
      txn(1'b1, 1'b0, 32'h10, '0, 32'hA5A5_A5A5, "rd_p1");
   endtask

   task automatic test_round_robin();
      exp_t e;
      int   acks = 0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_p0r = '0; exp_p1r = '0; t_exp_p0r = '0; t_exp_p1r = '0;
      p0_req = 1'b1; p0_rw = 1'b0; p0_addr = 32'h10;
      p1_req = 1'b1; p1_rw = 1'b0; p1_addr = 32'h14;
      for (int i = 0; i < 4; i++) begin
         e.port = i[0];
         e.d0   = 32'hA5A5_A5A5;
         e.d1   = (i == 0) ? 32'h0 : 32'h1234_5678;
         sb.push_back(e);
      end
      for (int k = 1; k <= 60 && acks < 4; k++) begin
         @(negedge clk);
         if (p0_ack || p1_ack) begin
            e = sb.pop_front();
            tests_run++;
            if (p0_ack && p1_ack) begin
               fails++;
               $display("FAIL rr_simultaneous: both acks high at cycle %0d", k);
            end
            tests_run++;
            if ({p0_ack, p1_ack} !== (e.port ? 2'b01 : 2'b10)) begin
               fails++;
               $display("FAIL rr_order_%0d: got acks %b required %b", acks, {p0_ack, p1_ack},
                        (e.port ? 2'b01 : 2'b10));
            end
            tests_run++;
            if ({p0_data_r, p1_data_r} !== {e.d0, e.d1}) begin
               fails++;
               $display("FAIL rr_data_%0d: got %h required %h", acks, {p0_data_r, p1_data_r}, {e.d0, e.d1});
            end
            acks++;
         end
      end
      p0_req = 1'b0; p1_req = 1'b0;
      tests_run++;
      if (acks != 4) begin
         fails++;
         $display("FAIL rr_count: got %0d acks required 4", acks);
         sb.delete();
      end
      exp_p0r = 32'hA5A5_A5A5; exp_p1r = 32'h1234_5678;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_latency3();
      exp_t e;
      bit   got = 0;
      e.port = 1'b0; e.d0 = 32'h0000_0100 ^ 32'h5A5A_0000; e.d1 = t_exp_p1r;
      sb.push_back(e);
      t_p0_req = 1'b1; t_p0_rw = 1'b0; t_p0_addr = 32'h100;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         tests_run++;
         if (t_m_op !== (k == 1)) begin
            fails++;
            $display("FAIL l3_mop: cycle %0d got %b required %b", k, t_m_op, (k == 1));
         end
         tests_run++;
         if (t_busy !== (k <= 4)) begin
            fails++;
            $display("FAIL l3_busy: cycle %0d got %b required %b", k, t_busy, (k <= 4));
         end
         if (t_p0_ack || t_p1_ack) begin
            got = 1;
            e = sb.pop_front();
            tests_run++;
            if (k != 4 || t_p1_ack !== 1'b0) begin
               fails++;
               $display("FAIL l3_ack: cycle %0d acks %b required cycle 4 acks 10", k, {t_p0_ack, t_p1_ack});
            end
            tests_run++;
            if ({t_p0_data_r, t_p1_data_r} !== {e.d0, e.d1}) begin
               fails++;
               $display("FAIL l3_data_r: got %h required %h", {t_p0_data_r, t_p1_data_r}, {e.d0, e.d1});
            end
            t_exp_p0r = e.d0; t_exp_p1r = e.d1;
            t_p0_req = 1'b0;
         end
      end
      t_p0_req = 1'b0;
      if (!got) begin
         tests_run++; fails++;
         $display("FAIL l3_timeout: no ack within 6 cycles");
         void'(sb.pop_front());
      end
   endtask

   task automatic test_reset_mid();
      t_p1_req = 1'b1; t_p1_rw = 1'b0; t_p1_addr = 32'h200;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({t_busy, t_m_op} !== 2'b10) begin
         fails++;
         $display("FAIL rstmid_in_wait: got busy/op %b required 10", {t_busy, t_m_op});
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if ({t_m_op, t_m_rw, t_m_addr, t_m_data_w, t_p0_ack, t_p1_ack, t_p0_data_r, t_p1_data_r, t_busy} !== '0) begin
         fails++;
         $display("FAIL rstmid_l3_zero: got %h required 0",
                  {t_m_op, t_m_rw, t_m_addr, t_m_data_w, t_p0_ack, t_p1_ack, t_p0_data_r, t_p1_data_r, t_busy});
      end
      tests_run++;
      if ({m_op, m_addr, p0_ack, p1_ack, p0_data_r, p1_data_r, busy} !== '0) begin
         fails++;
         $display("FAIL rstmid_l1_zero: got %h required 0",
                  {m_op, m_addr, p0_ack, p1_ack, p0_data_r, p1_data_r, busy});
      end
      t_p1_req = 1'b0;
      exp_p0r = '0; exp_p1r = '0; t_exp_p0r = '0; t_exp_p1r = '0;
      @(negedge clk);
      rst = 1'b0;
      txn(1'b0, 1'b0, 32'h10, '0, 32'hA5A5_A5A5, "post_rst_p0");
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if ({t_p1_ack, t_busy} !== 2'b00) begin
            fails++;
            $display("FAIL rstmid_no_ack: got ack/busy %b required 00", {t_p1_ack, t_busy});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_addr_change();
      exp_t e;
      bit   got = 0;
      e.port = 1'b1; e.d0 = t_exp_p0r; e.d1 = 32'h0000_0040 ^ 32'h5A5A_0000;
      sb.push_back(e);
      t_p1_req = 1'b1; t_p1_rw = 1'b0; t_p1_addr = 32'h40;
      for (int k = 1; k <= 8 && !got; k++) begin
         @(negedge clk);
         tests_run++;
         if (t_m_addr !== 32'h40) begin
            fails++;
            $display("FAIL addr_hold: cycle %0d got m_addr %h required 00000040", k, t_m_addr);
         end
         if (k == 2) t_p1_addr = 32'h80;
         if (t_p0_ack || t_p1_ack) begin
            got = 1;
            e = sb.pop_front();
            tests_run++;
            if (k != 4 || t_p0_ack !== 1'b0) begin
               fails++;
               $display("FAIL addr_ack: cycle %0d acks %b required cycle 4 acks 01", k, {t_p0_ack, t_p1_ack});
            end
            tests_run++;
            if ({t_p0_data_r, t_p1_data_r} !== {e.d0, e.d1}) begin
               fails++;
               $display("FAIL addr_data_r: got %h required %h", {t_p0_data_r, t_p1_data_r}, {e.d0, e.d1});
            end
         end
      end
      t_p1_req = 1'b0;
      if (!got) begin
         tests_run++; fails++;
         $display("FAIL addr_timeout: no ack within 8 cycles");
         void'(sb.pop_front());
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      p0_req = 1'b0; p1_req = 1'b0; p0_rw = 1'b0; p1_rw = 1'b0;
      p0_addr = '0; p1_addr = '0; p0_data_w = '0; p1_data_w = '0;
      t_p0_req = 1'b0; t_p1_req = 1'b0; t_p0_rw = 1'b0; t_p1_rw = 1'b0;
      t_p0_addr = '0; t_p1_addr = '0; t_p0_data_w = '0; t_p1_data_w = '0;
      exp_p0r = '0; exp_p1r = '0; t_exp_p0r = '0; t_exp_p1r = '0;
      @(negedge clk);
      test_reset();
      test_write_p0();
      test_back_to_back();
      test_read_p1();
      test_round_robin();
      test_latency3();
      test_reset_mid();
      test_addr_change();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
